// File: rtl/packed_stream_sink.sv
// Bit-reversing packet sink: each network vector becomes a WORDS-word packet held in a DEPTH-entry FIFO.
// Optional macro SINK_ZERO_SKIP_EN drops all-zero vectors after the handshake instead of queueing them.
module packed_stream_sink #(
    parameter int NUM_OUT   = 12,
    parameter int SNK_WIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 net_valid,
    output logic                 net_ready,
    input  logic [NUM_OUT-1:0]   net_out,
    input  logic                 snk_ready,
    output logic                 snk_valid,
    output logic [SNK_WIDTH-1:0] snk,
    output logic                 snk_last
);
    localparam int WORDS = (NUM_OUT + SNK_WIDTH - 1) / SNK_WIDTH;
    localparam int PW    = WORDS * SNK_WIDTH;
    localparam int PAD   = PW - NUM_OUT;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [NUM_OUT-1:0]   rev_vec;
    logic [PW-1:0]        packed_vec;
    logic [PW-1:0]        fifo_mem [DEPTH];
    logic [PW-1:0]        head_vec;
    logic [SNK_WIDTH-1:0] head_words [WORDS];
    logic [SNK_WIDTH-1:0] cur_word;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic full, empty, last_word;
    logic accept, push, pop_word, pop;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_rev
            assign rev_vec[NUM_OUT-1-gi] = net_out[gi];
        end
        // Pad lands in the LSBs so the last word carries the trailing zeros.
        if (PAD > 0) begin : g_pad
            assign packed_vec = {rev_vec, {PAD{1'b0}}};
        end else begin : g_nopad
            assign packed_vec = rev_vec;
        end
        for (gi = 0; gi < WORDS; gi++) begin : g_words
            assign head_words[gi] = head_vec[(WORDS-gi)*SNK_WIDTH-1 -: SNK_WIDTH];
        end
    endgenerate

    assign head_vec  = fifo_mem[rd_ptr_q];
    assign cur_word  = head_words[idx_q];
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign last_word = (idx_q == IDX_W'(WORDS - 1));

    // Outputs are forced low while reset is asserted, independent of stale state.
    assign net_ready = arstn && !full;
    assign snk_valid = arstn && !empty;
    assign snk       = snk_valid ? cur_word : '0;
    assign snk_last  = snk_valid && last_word;

    assign accept   = net_valid && net_ready;
`ifdef SINK_ZERO_SKIP_EN
    assign push     = accept && (net_out != '0);
`else
    assign push     = accept;
`endif
    assign pop_word = snk_valid && snk_ready;
    assign pop      = pop_word && last_word;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        idx_d    = idx_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            idx_d    = '0;
        end else if (pop_word) begin
            idx_d = idx_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            idx_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= packed_vec;
        end
    end
endmodule

// File: tb/tb_packed_stream_sink.sv
// Scoreboard bench for packed_stream_sink: driver queues expected words, negedge monitor checks them.
// Honours SINK_ZERO_SKIP_EN the same way the design does.
module tb_packed_stream_sink;
    localparam int NUM_OUT   = 12;
    localparam int SNK_WIDTH = 8;
    localparam int DEPTH     = 4;
    localparam int WORDS     = (NUM_OUT + SNK_WIDTH - 1) / SNK_WIDTH;

    logic                 clk = 1'b0;
    logic                 arstn;
    logic                 net_valid;
    logic                 net_ready;
    logic [NUM_OUT-1:0]   net_out;
    logic                 snk_ready;
    logic                 snk_valid;
    logic [SNK_WIDTH-1:0] snk;
    logic                 snk_last;

    packed_stream_sink #(.NUM_OUT(NUM_OUT), .SNK_WIDTH(SNK_WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .arstn(arstn),
        .net_valid(net_valid), .net_ready(net_ready), .net_out(net_out),
        .snk_ready(snk_ready), .snk_valid(snk_valid), .snk(snk), .snk_last(snk_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [SNK_WIDTH:0] exp_q [$];
    int   model_count = 0;
    bit   rand_ready  = 0;
    bit   prev_stall  = 0;
    logic [SNK_WIDTH+1:0] prev_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference packing: reverse bit order arithmetically, left-justify, slice into words.
    function automatic void push_model(input logic [NUM_OUT-1:0] v);
        longint unsigned r;
        longint unsigned p;
        longint unsigned w;
        r = 0;
`ifdef SINK_ZERO_SKIP_EN
        if (v == 0) return;
`endif
        for (int i = 0; i < NUM_OUT; i++)
            if (v[i]) r = r | (64'd1 << (NUM_OUT - 1 - i));
        p = r << (WORDS * SNK_WIDTH - NUM_OUT);
        for (int k = 0; k < WORDS; k++) begin
            w = (p >> ((WORDS - 1 - k) * SNK_WIDTH)) & ((64'd1 << SNK_WIDTH) - 1);
            exp_q.push_back({(k == WORDS - 1), w[SNK_WIDTH-1:0]});
        end
    endfunction

    // mode 0: model, 1: explicit words w0/w1, 2: nothing queued
    task automatic send(input logic [NUM_OUT-1:0] v, input int mode,
                        input logic [SNK_WIDTH-1:0] w0, input logic [SNK_WIDTH-1:0] w1);
        int  cyc;
        bit  done;
        cyc  = 0;
        done = 0;
        net_out   = v;
        net_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (net_ready) begin
                done = 1;
                if (mode == 0) push_model(v);
                else if (mode == 1) begin
                    exp_q.push_back({1'b0, w0});
                    exp_q.push_back({1'b1, w1});
                end
                $display("push net_out=%h", v);
            end else if (++cyc > 500) begin
                check("push_timeout", 32'(cyc), 32'd0);
                done = 1;
            end
        end
        @(posedge clk); #1;
        net_valid = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        logic [SNK_WIDTH:0] e;
        if (!arstn) begin
            check("rst_net_ready", 32'(net_ready), 32'd0);
            check("rst_snk_valid", 32'(snk_valid), 32'd0);
            check("rst_snk",       32'(snk),       32'd0);
            check("rst_snk_last",  32'(snk_last),  32'd0);
            exp_q.delete();
            model_count = 0;
            prev_stall  = 0;
        end else begin
            check("net_ready", 32'(net_ready), 32'(model_count < DEPTH));
            check("snk_valid", 32'(snk_valid), 32'(model_count > 0));
            if (!snk_valid) begin
                check("idle_snk",      32'(snk),      32'd0);
                check("idle_snk_last", 32'(snk_last), 32'd0);
            end
            if (prev_stall)
                check("stall_stable", 32'({snk_valid, snk_last, snk}), 32'(prev_out));
            if (snk_valid && snk_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(snk), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("snk_word", 32'(snk),      32'(e[SNK_WIDTH-1:0]));
                    check("snk_last", 32'(snk_last), 32'(e[SNK_WIDTH]));
                    $display("word snk=%h last=%0b exp=%h/%0b", snk, snk_last, e[SNK_WIDTH-1:0], e[SNK_WIDTH]);
                    if (e[SNK_WIDTH]) model_count--;
                end
            end
`ifdef SINK_ZERO_SKIP_EN
            if (net_valid && net_ready && net_out != 0) model_count++;
`else
            if (net_valid && net_ready) model_count++;
`endif
            prev_stall = snk_valid && !snk_ready;
            prev_out   = {snk_valid, snk_last, snk};
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) snk_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int cyc;
        arstn     = 1'b0;
        net_valid = 1'b1;
        net_out   = 12'h123;
        snk_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        arstn     = 1'b1;
        net_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send(12'hABC, 1, 8'h3D, 8'h50);
        drain();
        send(12'h001, 1, 8'h80, 8'h00);
        drain();

        snk_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(12'($urandom), 0, 8'h00, 8'h00);
        fork
            send(12'($urandom), 0, 8'h00, 8'h00);
            begin
                repeat (4) @(posedge clk);
                #1;
                snk_ready = 1'b1;
            end
        join
        drain();

        rand_ready = 1;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(12'($urandom), 0, 8'h00, 8'h00);
        end
        rand_ready = 0;
        @(posedge clk); #2;
        snk_ready = 1'b1;
        drain();

`ifdef SINK_ZERO_SKIP_EN
        send(12'h000, 2, 8'h00, 8'h00);
`else
        send(12'h000, 1, 8'h00, 8'h00);
`endif
        send(12'hABC, 1, 8'h3D, 8'h50);
        drain();

        send(12'hABC, 1, 8'h3D, 8'h50);
        cyc = 0;
        while (exp_q.size() != 1 && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("midpkt_word0_seen", 32'(exp_q.size()), 32'd1);
        @(posedge clk); #1;
        arstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send(12'hABC, 1, 8'h3D, 8'h50);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
